// File: rtl/craft_pkg.sv
// Shared constants, scan FSM state type and helpers for the pixel scan generator.
package craft_pkg;

    localparam int unsigned H_RES_DEFAULT = 800;
    localparam int unsigned V_RES_DEFAULT = 600;
    localparam int unsigned MAX_SPP_LOG2  = 7;
    localparam int unsigned COORD_W       = 10;
    localparam int unsigned SAMPLE_W      = MAX_SPP_LOG2;
    localparam int unsigned SPP_W         = 3;
    localparam int unsigned COUNT_W       = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } scan_state_e;

    // Highest sample index for a pixel: 2^spp_log2 - 1.
    function automatic logic [SAMPLE_W-1:0] last_sample(input logic [SPP_W-1:0] spp_log2);
        logic [SAMPLE_W:0] one_hot;
        one_hot = (SAMPLE_W + 1)'(1) << spp_log2;
        return SAMPLE_W'(one_hot - 1'b1);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Enable-gated shift register that models the downstream sampler pipeline depth.
module valid_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (enable) begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_scan_generator.sv
// Walks every sample of every pixel of one frame in raster order, then drains the
// sampler pipeline before signalling frame completion.
module pixel_scan_generator
    import craft_pkg::*;
#(
    parameter int unsigned H_RES           = H_RES_DEFAULT,
    parameter int unsigned V_RES           = V_RES_DEFAULT,
    parameter int unsigned SAMPLER_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic [SPP_W-1:0]    spp_log2,
    output logic [COORD_W-1:0]  pixel_x,
    output logic [COORD_W-1:0]  pixel_y,
    output logic [SAMPLE_W-1:0] sample_idx,
    output logic                pixel_valid,
    output logic                out_valid,
    output logic                out_last,
    output logic                busy,
    output logic                frame_done,
    output logic [COUNT_W-1:0]  frame_count
);

    localparam int unsigned DRAIN_W = (SAMPLER_LATENCY > 1) ? $clog2(SAMPLER_LATENCY) : 1;
    localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_RES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SAMPLER_LATENCY - 1);

    scan_state_e          state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [SAMPLE_W-1:0]  s_q, s_d;
    logic                 valid_q, valid_d;
    logic [SPP_W-1:0]     spp_q, spp_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 at_sample_end;
    logic                 at_row_end;
    logic                 at_frame_end;
    logic                 req_last;
    logic [1:0]           delay_dout;

    assign at_sample_end = (s_q == last_sample(spp_q));
    assign at_row_end    = (x_q == X_LAST);
    assign at_frame_end  = at_sample_end && at_row_end && (y_q == Y_LAST);
    assign req_last      = valid_q && at_frame_end;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        valid_d = valid_q;
        spp_d   = spp_q;
        drain_d = drain_q;
        count_d = count_q;
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StScan;
                        x_d     = '0;
                        y_d     = '0;
                        s_d     = '0;
                        valid_d = 1'b1;
                        spp_d   = spp_log2;
                    end
                end
                StScan: begin
                    if (at_frame_end) begin
                        state_d = StDrain;
                        valid_d = 1'b0;
                        drain_d = '0;
                    end else if (!at_sample_end) begin
                        s_d = s_q + 1'b1;
                    end else begin
                        s_d = '0;
                        if (at_row_end) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // The last request enters the delay line on the SCAN->DRAIN edge, so it
                    // reaches the output on the final enabled DRAIN cycle.
                    if (drain_q == DRAIN_LAST) begin
                        state_d = StDone;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    count_d = count_q + 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            spp_q   <= '0;
            drain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            spp_q   <= spp_d;
            drain_q <= drain_d;
            count_q <= count_d;
        end
    end

    valid_delay_line #(
        .DEPTH (SAMPLER_LATENCY),
        .WIDTH (2)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .enable (!stall),
        .din    ({valid_q, req_last}),
        .dout   (delay_dout)
    );

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign sample_idx  = s_q;
    assign pixel_valid = valid_q;
    assign out_valid   = delay_dout[1];
    assign out_last    = delay_dout[0];
    assign busy        = (state_q != StIdle);
    // Gated by stall so a held DONE state yields a single pulse on the cycle it actually exits.
    assign frame_done  = (state_q == StDone) && !stall;
    assign frame_count = count_q;

endmodule

// File: tb/tb_pixel_scan_generator.sv
// Scoreboard bench: a raster-order frame model feeds request/output queues that a
// negedge monitor drains while randomized and directed stimulus runs.
module tb_pixel_scan_generator;

    localparam int unsigned H   = 4;
    localparam int unsigned V   = 2;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [2:0]  spp_log2;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [6:0]  sample_idx;
    logic        pixel_valid;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    pixel_scan_generator #(
        .H_RES           (H),
        .V_RES           (V),
        .SAMPLER_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .spp_log2    (spp_log2),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .sample_idx  (sample_idx),
        .pixel_valid (pixel_valid),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [6:0] s;
        logic       last;
    } req_t;

    req_t req_q[$];
    logic out_q[$];

    int checks = 0;
    int passes = 0;
    int cycle = 0;
    int last_req_cyc = 0;
    int done_pulses = 0;
    int exp_frames = 0;
    bit nostall_frame = 1'b0;
    bit in_scan = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Reference frame: rows outer, columns middle, samples inner.
    task automatic push_frame(input int spp);
        int n;
        n = 1 << spp;
        for (int y = 0; y < int'(V); y++) begin
            for (int x = 0; x < int'(H); x++) begin
                for (int s = 0; s < n; s++) begin
                    req_t r;
                    r.x    = 10'(x);
                    r.y    = 10'(y);
                    r.s    = 7'(s);
                    r.last = (y == int'(V) - 1) && (x == int'(H) - 1) && (s == n - 1);
                    req_q.push_back(r);
                    out_q.push_back(r.last);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            req_t e;
            logic exp_last;
            if (pixel_valid) begin
                if (req_q.size() == 0) begin
                    check("extra_request", 32'd1, 32'd0);
                end else begin
                    e = req_q[0];
                    check("request_xys", {5'd0, pixel_x, pixel_y, sample_idx}, {5'd0, e.x, e.y, e.s});
                    if (!stall) begin
                        void'(req_q.pop_front());
                        in_scan = (req_q.size() != 0);
                        if (e.last) last_req_cyc = cycle;
                    end
                end
            end else if (in_scan) begin
                check("request_gap", 32'd0, 32'd1);
                in_scan = 1'b0;
            end
            if (out_valid && !stall) begin
                if (out_q.size() == 0) begin
                    check("extra_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_last = out_q.pop_front();
                    check("out_last", 32'(out_last), 32'(exp_last));
                    if (exp_last && nostall_frame)
                        check("out_last_latency", cycle - last_req_cyc, LAT);
                end
            end else if (!out_valid && out_last) begin
                check("out_last_without_valid", 32'd1, 32'd0);
            end
            if (frame_done) begin
                done_pulses++;
                if (nostall_frame) check("frame_done_latency", cycle - last_req_cyc, LAT + 1);
            end
        end
    end

    // mode 0: no stall; 1: random stall/start/spp; 2: stall 5 cycles at request 12;
    // 3: start with spp_log2=3 while busy; 4: stall 4 cycles in DONE.
    task automatic run_frame(input int spp, input int mode);
        int i;
        int done_stalls;
        push_frame(spp);
        done_pulses   = 0;
        done_stalls   = 0;
        nostall_frame = (mode == 0) || (mode == 3);
        @(posedge clk); #1;
        spp_log2 = 3'(spp);
        start    = 1'b1;
        stall    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        while (done_pulses == 0 && i < 4000) begin
            case (mode)
                1: begin
                    stall    = ($urandom_range(0, 4) == 0);
                    start    = ($urandom_range(0, 7) == 0);
                    spp_log2 = 3'($urandom);
                end
                2: stall = (i >= 12) && (i < 17);
                3: begin
                    start = (i == 5);
                    if (i == 5) spp_log2 = 3'd3;
                end
                4: begin
                    if (out_q.size() == 0 && done_stalls < 4) begin
                        stall = 1'b1;
                        done_stalls++;
                    end else begin
                        stall = 1'b0;
                    end
                end
                default: stall = 1'b0;
            endcase
            @(posedge clk); #1;
            i++;
        end
        start = 1'b0;
        stall = 1'b0;
        check("frame_done_seen", 32'(done_pulses), 32'd1);
        if (done_pulses != 0) exp_frames++;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("frame_done_once", 32'(done_pulses), 32'd1);
        check("frame_count", 32'(frame_count), 32'(exp_frames));
        check("busy_after_frame", 32'(busy), 32'd0);
        check("requests_consumed", 32'(req_q.size()), 32'd0);
        check("outputs_consumed", 32'(out_q.size()), 32'd0);
        if (mode == 4) check("done_stall_cycles", 32'(done_stalls), 32'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_x"}, 32'(pixel_x), 32'd0);
        check({tag, "_pixel_y"}, 32'(pixel_y), 32'd0);
        check({tag, "_sample_idx"}, 32'(sample_idx), 32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        spp_log2 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Asynchronous reset in the middle of a scan abandons the frame.
        push_frame(1);
        done_pulses = 0;
        @(posedge clk); #1;
        spp_log2 = 3'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midscan_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        req_q.delete();
        out_q.delete();
        in_scan = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("no_done_after_reset", 32'(done_pulses), 32'd0);
        check("count_after_reset", 32'(frame_count), 32'd0);
        check("idle_after_reset", 32'(busy), 32'd0);

        run_frame(1, 0);
        run_frame(1, 2);
        run_frame(1, 3);
        run_frame(0, 4);
        run_frame(7, 0);
        for (int k = 0; k < 6; k++) run_frame(int'($urandom_range(0, 4)), 1);
        run_frame(2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
